// File: rtl/testport_write_capture_if.sv
// Test-port capture bus: D-mem write snoop inputs plus the valid/ready result stream.
// The master is the CPU/consumer side; the slave is the capture block.
interface testport_write_capture_if;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_stamp;
  logic        out_ready;

  modport master (
    output addr,
    output data,
    output wen,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_stamp
  );

  modport slave (
    input  addr,
    input  data,
    input  wen,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_stamp
  );
endinterface

// File: rtl/testport_write_capture.sv
// Snoops D-mem writes to the test port, counts each stalled write once, byte-swaps it and queues
// words between the begin and end markers. Optional macro TESTPORT_STAMP_EN adds per-entry cycle stamps.
module testport_write_capture #(
  parameter logic [29:0] TEST_PORT    = 30'h10,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int          DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  testport_write_capture_if.slave      bus,
  output logic                         active,
  output logic                         done,
  output logic                         overflow,
  output logic [7:0]                   word_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             wen_q_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [31:0]      mem_r [DEPTH];
  logic [7:0]       word_cnt_r;
  logic             overflow_r;
  logic             active_r;
  logic             done_r;
  logic             out_valid_r;

  logic [31:0]      swapped_s;
  logic             hit_s;
  logic             event_s;
  logic             begin_s;
  logic             push_req_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  assign swapped_s = byte_swap(bus.data);
  assign hit_s     = bus.wen && (bus.addr == TEST_PORT);
  // Only the first cycle of a (possibly stalled) write counts as an event.
  assign event_s   = hit_s && !wen_q_r;
  assign full_s    = (count_r == FULL_CNT);
  assign pop_s     = out_valid_r && bus.out_ready;
  assign push_s    = push_req_s && (!full_s || pop_s);
  assign drop_s    = push_req_s && full_s && !pop_s;

  // Next-state decode of the capture window.
  always_comb begin
    state_nxt_s = state_r;
    begin_s     = 1'b0;
    push_req_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (event_s && (swapped_s == BEGIN_SYMBOL)) begin
          state_nxt_s = ST_CAPTURE;
          begin_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (event_s) begin
          push_req_s = 1'b1;
          // A dropped end marker still closes the window.
          if (swapped_s == END_SYMBOL) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // State register and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      wen_q_r  <= 1'b0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      wen_q_r  <= bus.wen;
      active_r <= (state_nxt_s == ST_CAPTURE);
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  // FIFO pointers, occupancy and head-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // FIFO data storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= swapped_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Word counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      if (begin_s) begin
        word_cnt_r <= 8'h00;
      end else if (push_s && (word_cnt_r != 8'hFF)) begin
        word_cnt_r <= word_cnt_r + 8'h01;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

`ifdef TESTPORT_STAMP_EN
  logic [15:0] stamp_r;
  logic [15:0] stamp_mem_r [DEPTH];

  // Cycle stamp counter, running only while the window is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      stamp_r <= 16'h0000;
    end else if (begin_s) begin
      stamp_r <= 16'h0000;
    end else if (state_r == ST_CAPTURE) begin
      stamp_r <= stamp_r + 16'h0001;
    end else begin
      stamp_r <= stamp_r;
    end
  end

  // Stamp storage alongside each FIFO entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stamp_mem_r[i] <= 16'h0000;
      end
    end else if (push_s) begin
      stamp_mem_r[wr_ptr_r] <= stamp_r;
    end else begin
      stamp_mem_r[wr_ptr_r] <= stamp_mem_r[wr_ptr_r];
    end
  end

  assign bus.out_stamp = stamp_mem_r[rd_ptr_r];
`else
  assign bus.out_stamp = 16'h0000;
`endif

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = mem_r[rd_ptr_r];
  assign active        = active_r;
  assign done          = done_r;
  assign overflow      = overflow_r;
  assign word_cnt      = word_cnt_r;

endmodule
